data_capture: RTL and testbench
===============================

# data_capture

Write-side companion to the buffer-memory reader. It takes the per-frequency sample stream and writes each sample into the shared buffer memory at address {bank, sample_count, freq_index}. It keeps an independent sample counter and bank pointer for every frequency channel. When a channel fills one bank (DEPTH/ASSERT samples), it emits a one-cycle assert carrying {bank, index}, which the reader queues and drains.

## Interface
- DATA_WIDTH, 64, sample width
- N_FREQ, 128, number of frequency channels (power of two)
- DEPTH, 32, samples stored per channel across all banks (power of two)
- ASSERT, 2, number of banks per channel (power of two, ≥2, divides DEPTH)
- Derived: FW = $clog2(N_FREQ), BW = $clog2(ASSERT), CW = $clog2(DEPTH)-BW, COUNTER_MAX = DEPTH/ASSERT-1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- clear  in  1  synchronous clear of all channel counters/banks and n_assert
- en  in  1  capture enable
- din_valid  in  1  sample strobe
- din_data  in  DATA_WIDTH  sample
- din_index  in  FW  frequency channel of sample
- wr_en  out  1  memory write strobe
- wr_addr  out  FW+$clog2(DEPTH)  {bank[BW], count[CW], index[FW]}
- wr_data  out  DATA_WIDTH  memory write data
- assert  out  1  one-cycle bank-complete pulse
- assert_msb  out  BW  completed bank
- assert_index  out  FW  completed channel
- n_assert  out  32  total asserts issued, wraps at 2^32

## Operation
- Per channel i: cnt[i] (CW bits) and bank[i] (BW bits), all 0 after reset/clear.
- Accept = din_valid & en & ~clear & rst. On accept with index k:
  - write at {bank[k], cnt[k], k}, data din_data.
  - if cnt[k] == COUNTER_MAX: cnt[k] ← 0, bank[k] ← bank[k]+1 mod ASSERT, schedule assert {bank[k] (pre-increment), k}; else cnt[k] ← cnt[k]+1.
- Back-to-back samples on the same index must use the updated counter (no hazard); e.g. two consecutive k samples go to count 0 then 1.
- din_valid with en=0: sample dropped, no state change.
- clear=1: all cnt/bank ← 0, n_assert ← 0, input dropped that cycle. Writes and asserts already in the pipeline still complete.
- Completion ordering: a bank's assert never precedes its last write.
- No backpressure. Upstream guarantees a channel does not lap the reader; no overrun detection.
- n_assert increments on every assert pulse.

## Timing
- Sample accepted in cycle t → wr_en/wr_addr/wr_data registered, valid in cycle t+1.
- Completing sample at t → assert, assert_msb, assert_index high/valid in cycle t+2 only (one cycle after the final write is committed). n_assert reflects it at t+3.
- Throughput: one sample per cycle, any index sequence. Assert may pulse on consecutive cycles.
- Reset (rst=0) values: wr_en 0, wr_addr 0, wr_data 0, assert 0, assert_msb 0, assert_index 0, n_assert 0. All cnt/bank 0.
- Reset mid-operation: pipelined writes/asserts are discarded; outputs are 0 on the cycle after the rst=0 edge.
- wr_addr/wr_data hold their last value when wr_en=0. assert_msb/assert_index hold when assert=0.

## Test plan
- Reset → all outputs 0. Then 16 samples on index 5 (defaults): wr_addr = {0,c,5} for c = 0..15 on consecutive cycles. Single assert (msb=0, index=5) two cycles after the 16th accept. n_assert=1.
- 32 more samples on index 5: bank 1 filled (assert msb=1), then wrap to bank 0 (assert msb=0). Address 33rd overall = {0,0,5}.
- Interleave indices 0 and 127 each cycle for 32 cycles: both channels complete bank 0. Two asserts on consecutive cycles (index 0 then 127). Counters independent.
- en=0 for 4 cycles with din_valid=1: no wr_en, counters unchanged. clear asserted after 7 samples on index 3: next sample writes {0,0,3}, n_assert=0.
- rst=0 pulse one cycle after a completing sample: no assert emitted, all outputs 0. Subsequent sample on that index writes count 0, bank 0.
- Random stream of 10k samples, random en/valid, compared against a behavioural model of memory contents and the assert sequence. Every assert's bank contents must match the model at the assert cycle.

Source files
------------

// File: rtl/data_capture_if.sv
// data_capture_if: sample stream into the capture block; buffer-memory write port and bank-complete pulses out of it
// master: sample source / consumer side; slave: data_capture
interface data_capture_if #(
    parameter int DATA_WIDTH = 64,
    parameter int N_FREQ     = 128,
    parameter int DEPTH      = 32,
    parameter int ASSERT     = 2
);
    localparam int FW = $clog2(N_FREQ);
    localparam int BW = $clog2(ASSERT);
    localparam int AW = FW + $clog2(DEPTH);
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din_data;
    logic [FW-1:0]         din_index;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  assert_valid;
    logic [BW-1:0]         assert_msb;
    logic [FW-1:0]         assert_index;
    logic [31:0]           n_assert;
    modport master (
        output din_valid, din_data, din_index,
        input  wr_en, wr_addr, wr_data, assert_valid, assert_msb, assert_index, n_assert
    );
    modport slave (
        input  din_valid, din_data, din_index,
        output wr_en, wr_addr, wr_data, assert_valid, assert_msb, assert_index, n_assert
    );
endinterface

// File: rtl/data_capture.sv
// data_capture: writes per-channel samples into banked buffer memory and pulses when a channel fills a bank
// Ports: clk; rst (sync, active low); clear (sync clear of counters/banks/n_assert); en (capture enable);
//        bus (slave): din_valid/din_data/din_index in; wr_en/wr_addr/wr_data, assert_valid/assert_msb/assert_index, n_assert out
module data_capture #(
    parameter int DATA_WIDTH = 64,
    parameter int N_FREQ     = 128,
    parameter int DEPTH      = 32,
    parameter int ASSERT     = 2
) (
    input logic           clk,
    input logic           rst,
    input logic           clear,
    input logic           en,
    data_capture_if.slave bus
);
    localparam int FW = $clog2(N_FREQ);
    localparam int BW = $clog2(ASSERT);
    localparam int CW = $clog2(DEPTH) - BW;
    localparam int AW = FW + BW + CW;
    localparam logic [CW-1:0] COUNTER_MAX = CW'(DEPTH / ASSERT - 1);

    logic [CW-1:0]         cnt_q [N_FREQ];
    logic [BW-1:0]         bank_q [N_FREQ];
    logic                  accept, wrap;
    logic [CW-1:0]         cur_cnt, cnt_d;
    logic [BW-1:0]         cur_bank, bank_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  pend_q, pend_d;
    logic [BW-1:0]         pend_msb_q, pend_msb_d;
    logic [FW-1:0]         pend_idx_q, pend_idx_d;
    logic                  assert_q, assert_d;
    logic [BW-1:0]         assert_msb_q, assert_msb_d;
    logic [FW-1:0]         assert_index_q, assert_index_d;
    logic [31:0]           n_assert_q, n_assert_d;

    // Counter state is read and updated in the accept cycle, so back-to-back samples on one channel see fresh values
    always_comb begin
        accept         = bus.din_valid & en & ~clear & rst;
        cur_cnt        = cnt_q[bus.din_index];
        cur_bank       = bank_q[bus.din_index];
        wrap           = cur_cnt == COUNTER_MAX;
        cnt_d          = wrap ? '0 : cur_cnt + CW'(1);
        bank_d         = wrap ? cur_bank + BW'(1) : cur_bank;
        wr_en_d        = accept;
        wr_addr_d      = accept ? {cur_bank, cur_cnt, bus.din_index} : wr_addr_q;
        wr_data_d      = accept ? bus.din_data : wr_data_q;
        // One extra stage so the pulse lands a cycle after the bank's final write is committed
        pend_d         = accept & wrap;
        pend_msb_d     = cur_bank;
        pend_idx_d     = bus.din_index;
        assert_d       = pend_q;
        assert_msb_d   = pend_q ? pend_msb_q : assert_msb_q;
        assert_index_d = pend_q ? pend_idx_q : assert_index_q;
        n_assert_d     = clear ? '0 : n_assert_q + 32'(assert_q);
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < N_FREQ; i++) begin
                cnt_q[i]  <= '0;
                bank_q[i] <= '0;
            end
        end else if (accept) begin
            cnt_q[bus.din_index]  <= cnt_d;
            bank_q[bus.din_index] <= bank_d;
        end
    end

    // Clear leaves the write/assert pipeline alone so in-flight work still completes
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            pend_q         <= 1'b0;
            pend_msb_q     <= '0;
            pend_idx_q     <= '0;
            assert_q       <= 1'b0;
            assert_msb_q   <= '0;
            assert_index_q <= '0;
            n_assert_q     <= '0;
        end else begin
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            pend_q         <= pend_d;
            pend_msb_q     <= pend_msb_d;
            pend_idx_q     <= pend_idx_d;
            assert_q       <= assert_d;
            assert_msb_q   <= assert_msb_d;
            assert_index_q <= assert_index_d;
            n_assert_q     <= n_assert_d;
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.assert_valid = assert_q;
    assign bus.assert_msb   = assert_msb_q;
    assign bus.assert_index = assert_index_q;
    assign bus.n_assert     = n_assert_q;
endmodule

// File: tb/tb_data_capture.sv
// tb_data_capture: table vectors, directed corner sequences and a random stream checked against a sample-count model
module tb_data_capture;
    localparam int DW  = 64;
    localparam int NF  = 128;
    localparam int DP  = 32;
    localparam int AS  = 2;
    localparam int PER = DP / AS;

    logic clk, rst, clear, en;
    data_capture_if #(.DATA_WIDTH(DW), .N_FREQ(NF), .DEPTH(DP), .ASSERT(AS)) bus ();

    data_capture #(.DATA_WIDTH(DW), .N_FREQ(NF), .DEPTH(DP), .ASSERT(AS)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (en),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; int msb; int idx; } ev_t;
    typedef struct { bit v; bit e; bit c; int idx; bit we; int addr; } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          tot [NF];
    bit [63:0]   mmem [4096];
    bit [63:0]   dmem [4096];
    ev_t         evq [$];
    logic        e_we, e_as;
    logic [11:0] e_addr;
    logic [63:0] e_data;
    logic [0:0]  e_msb;
    logic [6:0]  e_idx;
    logic [31:0] e_n;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check every output
    task automatic step(input bit v, input bit e, input bit c, input bit r, input int idx, input logic [63:0] d);
        int  n, a;
        ev_t x;
        bit  ok;
        bus.din_valid = v;
        bus.din_data  = d;
        bus.din_index = 7'(idx);
        en            = e;
        clear         = c;
        rst           = r;
        @(posedge clk);
        cyc++;
        if (!r) begin
            evq.delete();
            e_we = 0; e_addr = 0; e_data = 0; e_as = 0; e_msb = 0; e_idx = 0; e_n = 0;
            foreach (tot[i]) tot[i] = 0;
        end else begin
            e_n  = c ? 32'd0 : e_n + 32'(e_as);
            e_as = 0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                x     = evq.pop_front();
                e_as  = 1;
                e_msb = 1'(x.msb);
                e_idx = 7'(x.idx);
            end
            if (v && e && !c) begin
                n       = tot[idx];
                a       = ((n / PER) % AS) * 2048 + (n % PER) * 128 + idx;
                mmem[a] = d;
                e_we    = 1;
                e_addr  = 12'(a);
                e_data  = d;
                if (n % PER == PER - 1) evq.push_back('{cyc + 1, (n / PER) % AS, idx});
                tot[idx] = (n + 1) % DP;
            end else e_we = 0;
            if (c) foreach (tot[i]) tot[i] = 0;
        end
        #1;
        cmp("wr_en", 64'(bus.wr_en), 64'(e_we));
        cmp("wr_addr", 64'(bus.wr_addr), 64'(e_addr));
        cmp("wr_data", bus.wr_data, e_data);
        cmp("assert", 64'(bus.assert_valid), 64'(e_as));
        cmp("assert_msb", 64'(bus.assert_msb), 64'(e_msb));
        cmp("assert_index", 64'(bus.assert_index), 64'(e_idx));
        cmp("n_assert", 64'(bus.n_assert), 64'(e_n));
        if (bus.wr_en === 1'b1) dmem[bus.wr_addr] = bus.wr_data;
        if (bus.assert_valid === 1'b1) begin
            ok = 1;
            for (int k = 0; k < PER; k++) begin
                a = int'(bus.assert_msb) * 2048 + k * 128 + int'(bus.assert_index);
                if (dmem[a] != mmem[a]) ok = 0;
            end
            cmp("bank_contents", 64'(ok), 64'd1);
        end
    endtask

    task automatic idle();
        step(0, 1, 0, 1, 0, 64'd0);
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        cmp({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
        cmp({tag, "_wr_data"}, bus.wr_data, 64'd0);
        cmp({tag, "_assert"}, 64'(bus.assert_valid), 64'd0);
        cmp({tag, "_assert_msb"}, 64'(bus.assert_msb), 64'd0);
        cmp({tag, "_assert_index"}, 64'(bus.assert_index), 64'd0);
        cmp({tag, "_n_assert"}, 64'(bus.n_assert), 64'd0);
    endtask

    initial begin
        vec_t tbl [8];
        bit   v, e, c, r;
        int   idx;
        tbl[0] = '{1, 1, 0, 5, 1, 5};
        tbl[1] = '{1, 0, 0, 5, 0, 5};
        tbl[2] = '{1, 1, 0, 5, 1, 133};
        tbl[3] = '{1, 1, 0, 9, 1, 9};
        tbl[4] = '{0, 1, 0, 5, 0, 9};
        tbl[5] = '{1, 1, 1, 5, 0, 9};
        tbl[6] = '{1, 1, 0, 5, 1, 5};
        tbl[7] = '{1, 1, 0, 5, 1, 133};
        rst = 0; clear = 0; en = 0;
        bus.din_valid = 0; bus.din_data = '0; bus.din_index = '0;

        step(0, 0, 0, 0, 0, 64'd0);
        check_zero("reset");
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].c, 1, tbl[i].idx, 64'h100 + 64'(i));
            cmp("tbl_wr_en", 64'(bus.wr_en), 64'(tbl[i].we));
            cmp("tbl_wr_addr", 64'(bus.wr_addr), 64'(tbl[i].addr));
            cmp("tbl_n_assert", 64'(bus.n_assert), 64'd0);
        end

        step(0, 0, 0, 0, 0, 64'd0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 1, 5, 64'hA000 + 64'(i));
            cmp("ch5_addr", 64'(bus.wr_addr), 64'(i * 128 + 5));
        end
        cmp("ch5_no_early_assert", 64'(bus.assert_valid), 64'd0);
        idle();
        cmp("ch5_assert", 64'(bus.assert_valid), 64'd1);
        cmp("ch5_assert_msb", 64'(bus.assert_msb), 64'd0);
        cmp("ch5_assert_index", 64'(bus.assert_index), 64'd5);
        idle();
        cmp("ch5_n_assert", 64'(bus.n_assert), 64'd1);

        for (int i = 0; i < 32; i++) begin
            step(1, 1, 0, 1, 5, 64'hB000 + 64'(i));
            if (i == 16) cmp("ch5_wrap_addr", 64'(bus.wr_addr), 64'd5);
        end
        idle();
        idle();
        cmp("ch5_n_assert3", 64'(bus.n_assert), 64'd3);

        for (int i = 0; i < 32; i++) step(1, 1, 0, 1, (i % 2 == 1) ? 127 : 0, 64'hC000 + 64'(i));
        cmp("pair_assert0", 64'(bus.assert_valid), 64'd1);
        cmp("pair_index0", 64'(bus.assert_index), 64'd0);
        idle();
        cmp("pair_assert1", 64'(bus.assert_valid), 64'd1);
        cmp("pair_index1", 64'(bus.assert_index), 64'd127);

        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 5, 64'hD000);
            cmp("en_off_wr_en", 64'(bus.wr_en), 64'd0);
        end
        step(1, 1, 0, 1, 5, 64'hD001);
        cmp("en_off_kept_addr", 64'(bus.wr_addr), 64'(2048 + 5));
        for (int i = 0; i < 7; i++) step(1, 1, 0, 1, 3, 64'hE000 + 64'(i));
        step(1, 1, 1, 1, 3, 64'hE0FF);
        cmp("clear_drop", 64'(bus.wr_en), 64'd0);
        step(1, 1, 0, 1, 3, 64'hE100);
        cmp("clear_addr", 64'(bus.wr_addr), 64'd3);
        cmp("clear_n_assert", 64'(bus.n_assert), 64'd0);

        for (int i = 0; i < 16; i++) step(1, 1, 0, 1, 8, 64'hF000 + 64'(i));
        step(0, 1, 0, 0, 0, 64'd0);
        check_zero("midreset");
        idle();
        cmp("midreset_no_assert", 64'(bus.assert_valid), 64'd0);
        step(1, 1, 0, 1, 8, 64'hF100);
        cmp("midreset_addr", 64'(bus.wr_addr), 64'd8);

        for (int i = 0; i < 10000; i++) begin
            v   = ($urandom % 4) != 0;
            e   = ($urandom % 8) != 0;
            c   = ($urandom % 700) == 0;
            r   = ($urandom % 1500) != 0;
            idx = (i % 2000 < 1000) ? int'($urandom % 6) : int'($urandom % NF);
            step(v, e, c, r, idx, {$urandom, $urandom});
        end
        idle();
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
